// File: rtl/seven_segment_scanner.sv
// Multiplexed seven-segment scanner: time-slices NUM_DIGITS hex digits onto one segment bus,
// with tear-free frame-synchronous updates, anode dead time and optional leading-zero blanking.
module seven_segment_scanner #(
  parameter int NUM_DIGITS     = 4,
  parameter int CLKS_PER_DIGIT = 25000,
  parameter int DEAD_CLKS      = 16,
  parameter int ACTIVE_LOW     = 1
) (
  input  logic                    i_Clk,
  input  logic                    i_Rst,
  input  logic [4*NUM_DIGITS-1:0] i_Data,
  input  logic                    i_Data_DV,
  input  logic [NUM_DIGITS-1:0]   i_DP,
  input  logic                    i_Blank_En,
  output logic [6:0]              o_Segment,
  output logic                    o_DP,
  output logic [NUM_DIGITS-1:0]   o_Anode,
  output logic                    o_Frame_Done
);

  localparam int CNT_W = $clog2(CLKS_PER_DIGIT);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int WORD_W = 5 * NUM_DIGITS + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_DIGIT - 1);
  localparam logic [CNT_W-1:0] DEAD_END = CNT_W'(DEAD_CLKS);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic             POL      = (ACTIVE_LOW != 0);

  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [WORD_W-1:0]     pend_q, pend_d;
  logic [WORD_W-1:0]     disp_q, disp_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic [NUM_DIGITS-1:0] anode_q, anode_d;
  logic                  frame_done_q;

  logic                    frame_end;
  logic [WORD_W-1:0]       in_word;
  logic [4*NUM_DIGITS-1:0] disp_data;
  logic [NUM_DIGITS-1:0]   disp_dp;
  logic                    disp_blank;
  logic [NUM_DIGITS-1:0]   blank_vec;
  logic                    zero_run;
  logic [3:0]              cur_nib;
  logic                    cur_dp;
  logic                    cur_blank;
  logic                    show;
  logic [6:0]              dec_hi;
  logic [NUM_DIGITS-1:0]   anode_hi;

  assign frame_end  = (cnt_q == CNT_LAST) && (idx_q == IDX_LAST);
  assign in_word    = {i_Blank_En, i_DP, i_Data};
  assign disp_data  = disp_q[4*NUM_DIGITS-1:0];
  assign disp_dp    = disp_q[5*NUM_DIGITS-1:4*NUM_DIGITS];
  assign disp_blank = disp_q[WORD_W-1];

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    idx_d = idx_q;
    if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end
  end

  // A strobe on the boundary cycle bypasses pending, but still lands in pending so
  // the next boundary copy does not resurrect older data.
  always_comb begin
    pend_d = i_Data_DV ? in_word : pend_q;
    disp_d = disp_q;
    if (frame_end) begin
      disp_d = i_Data_DV ? in_word : pend_q;
    end
  end

  // Walk from the most-significant digit down while the digits stay zero.
  always_comb begin
    zero_run  = 1'b1;
    blank_vec = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      zero_run     = zero_run && (disp_data[4*k +: 4] == 4'd0);
      blank_vec[k] = disp_blank && zero_run && (k != 0);
    end
  end

  always_comb begin
    cur_nib   = 4'd0;
    cur_dp    = 1'b0;
    cur_blank = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx_q == IDX_W'(k)) begin
        cur_nib   = disp_data[4*k +: 4];
        cur_dp    = disp_dp[k];
        cur_blank = blank_vec[k];
      end
    end
  end

  assign show = (cnt_q >= DEAD_END) && !cur_blank;

  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_anode
      assign anode_hi[gi] = show && (idx_q == IDX_W'(gi));
    end
  endgenerate

  always_comb begin
    dec_hi = 7'h00;
    case (cur_nib)
      4'h0: dec_hi = 7'h3F;
      4'h1: dec_hi = 7'h06;
      4'h2: dec_hi = 7'h5B;
      4'h3: dec_hi = 7'h4F;
      4'h4: dec_hi = 7'h66;
      4'h5: dec_hi = 7'h6D;
      4'h6: dec_hi = 7'h7D;
      4'h7: dec_hi = 7'h07;
      4'h8: dec_hi = 7'h7F;
      4'h9: dec_hi = 7'h6F;
      4'hA: dec_hi = 7'h77;
      4'hB: dec_hi = 7'h7C;
      4'hC: dec_hi = 7'h39;
      4'hD: dec_hi = 7'h5E;
      4'hE: dec_hi = 7'h79;
      4'hF: dec_hi = 7'h71;
      default: dec_hi = 7'h00;
    endcase
  end

  always_comb begin
    seg_d   = (show ? dec_hi : 7'h00) ^ {7{POL}};
    dp_d    = (show && cur_dp) ^ POL;
    anode_d = anode_hi ^ {NUM_DIGITS{POL}};
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      pend_q       <= '0;
      disp_q       <= '0;
      seg_q        <= {7{POL}};
      dp_q         <= POL;
      anode_q      <= {NUM_DIGITS{POL}};
      frame_done_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      pend_q       <= pend_d;
      disp_q       <= disp_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      anode_q      <= anode_d;
      frame_done_q <= frame_end;
    end
  end

  assign o_Segment    = seg_q;
  assign o_DP         = dp_q;
  assign o_Anode      = anode_q;
  assign o_Frame_Done = frame_done_q;

endmodule

// File: tb/tb_seven_segment_scanner.sv
// Bench for seven_segment_scanner (4 digits, 4 clocks/slot, 1 dead clock, active-low):
// per-cycle expected outputs are queued per frame and compared as the frame plays out.
module tb_seven_segment_scanner;

  logic        clk;
  logic        rst;
  logic [15:0] data;
  logic        dv;
  logic [3:0]  dp;
  logic        blank;
  logic [6:0]  seg;
  logic        dp_o;
  logic [3:0]  anode;
  logic        frame_done;

  seven_segment_scanner #(
    .NUM_DIGITS(4), .CLKS_PER_DIGIT(4), .DEAD_CLKS(1), .ACTIVE_LOW(1)
  ) dut (
    .i_Clk(clk), .i_Rst(rst), .i_Data(data), .i_Data_DV(dv), .i_DP(dp),
    .i_Blank_En(blank), .o_Segment(seg), .o_DP(dp_o), .o_Anode(anode),
    .o_Frame_Done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // seg holds the active-low pattern per digit as {d3,d2,d1,d0}; blanked marks suppressed digits.
  typedef struct {
    logic [15:0] data;
    logic [3:0]  dp;
    logic        blank;
    logic [27:0] seg;
    logic [3:0]  blanked;
  } vec_t;

  typedef logic [12:0] rec_t;  // {anode, segment, dp, frame_done}

  localparam rec_t RESET_REC = {4'hF, 7'h7F, 1'b1, 1'b0};

  vec_t vecs[8];
  vec_t reset_vec;
  vec_t prev;
  rec_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic rec_t exp_rec(vec_t v, int s);
    int         idx;
    int         cnt;
    logic [3:0] an;
    logic [6:0] sg;
    logic       d;
    logic [3:0] onehot;
    idx    = s / 4;
    cnt    = s % 4;
    an     = 4'hF;
    sg     = 7'h7F;
    d      = 1'b1;
    onehot = 4'b0001;
    if (cnt >= 1 && !v.blanked[idx]) begin
      onehot = onehot << idx;
      an     = ~onehot;
      sg     = v.seg[7*idx +: 7];
      d      = ~v.dp[idx];
    end
    return {an, sg, d, (s == 15)};
  endfunction

  task automatic push_frame(vec_t v, int n_slots);
    for (int s = 0; s < n_slots; s++) exp_q.push_back(exp_rec(v, s));
  endtask

  task automatic check_cycle(string tag);
    rec_t act;
    rec_t exp;
    act = {anode, seg, dp_o, frame_done};
    n_vec++;
    if (exp_q.size() == 0) begin
      n_err++;
      $display("FAIL %s: scoreboard empty, got anode=%h seg=%h dp=%b fd=%b",
               tag, act[12:9], act[8:2], act[1], act[0]);
    end else begin
      exp = exp_q.pop_front();
      if (act !== exp) begin
        n_err++;
        $display("FAIL %s @%0t: got anode=%h seg=%h dp=%b fd=%b, want anode=%h seg=%h dp=%b fd=%b",
                 tag, $time, act[12:9], act[8:2], act[1], act[0],
                 exp[12:9], exp[8:2], exp[1], exp[0]);
      end
    end
  endtask

  task automatic drive(vec_t v);
    data  = v.data;
    dp    = v.dp;
    blank = v.blank;
    dv    = 1'b1;
  endtask

  initial begin
    reset_vec = '{16'h0000, 4'b0000, 1'b0, {7'h40, 7'h40, 7'h40, 7'h40}, 4'b0000};
    vecs[0]   = '{16'h1234, 4'b0000, 1'b0, {7'h79, 7'h24, 7'h30, 7'h19}, 4'b0000};
    vecs[1]   = '{16'h0050, 4'b0000, 1'b1, {7'h40, 7'h40, 7'h12, 7'h40}, 4'b1100};
    vecs[2]   = '{16'hABCD, 4'b0101, 1'b0, {7'h08, 7'h03, 7'h46, 7'h21}, 4'b0000};
    vecs[3]   = '{16'h0000, 4'b1111, 1'b1, {7'h40, 7'h40, 7'h40, 7'h40}, 4'b1110};
    vecs[4]   = '{16'h9EF0, 4'b0000, 1'b1, {7'h10, 7'h06, 7'h0E, 7'h40}, 4'b0000};
    vecs[5]   = '{16'h0100, 4'b0000, 1'b1, {7'h40, 7'h79, 7'h40, 7'h40}, 4'b1000};
    vecs[6]   = '{16'h0000, 4'b0010, 1'b0, {7'h40, 7'h40, 7'h40, 7'h40}, 4'b0000};
    vecs[7]   = '{16'h5678, 4'b1010, 1'b1, {7'h12, 7'h02, 7'h78, 7'h00}, 4'b0000};

    rst = 1'b1; dv = 1'b0; data = 16'h0; dp = 4'h0; blank = 1'b0;
    repeat (2) begin
      @(negedge clk);
      exp_q.push_back(RESET_REC);
      check_cycle("reset");
    end
    rst  = 1'b0;
    prev = reset_vec;

    // Each vector: strobe at the start of frame A (old data must persist), frame B shows it.
    for (int i = 0; i < 8; i++) begin
      $display("vector %0d: data=%h dp=%b blank=%b", i, vecs[i].data, vecs[i].dp, vecs[i].blank);
      drive(vecs[i]);
      push_frame(prev, 16);
      push_frame(vecs[i], 16);
      for (int j = 1; j <= 32; j++) begin
        @(negedge clk);
        if (j == 1) dv = 1'b0;
        check_cycle($sformatf("vec%0d", i));
      end
      prev = vecs[i];
    end

    // Boundary-cycle strobe loads directly; later two strobes in one frame, last wins.
    $display("sequence: boundary strobe %h, then %h and %h in one frame",
             vecs[0].data, vecs[1].data, vecs[2].data);
    push_frame(prev, 16);
    push_frame(vecs[0], 16);
    push_frame(vecs[0], 16);
    push_frame(vecs[2], 16);
    for (int j = 1; j <= 64; j++) begin
      @(negedge clk);
      check_cycle("boundary");
      case (j)
        15: drive(vecs[0]);
        34: drive(vecs[1]);
        36: drive(vecs[2]);
        16, 35, 37: dv = 1'b0;
        default: ;
      endcase
    end
    prev = vecs[2];

    // Mid-frame reset during the digit-2 slot discards a pending 1111 and a strobe held in reset.
    $display("sequence: reset in digit-2 slot with pending data");
    data = 16'h1111; dp = 4'h0; blank = 1'b0; dv = 1'b1;
    push_frame(prev, 9);
    for (int j = 1; j <= 9; j++) begin
      @(negedge clk);
      if (j == 1) dv = 1'b0;
      check_cycle("pre_reset");
    end
    rst = 1'b1; dv = 1'b1; data = 16'hFFFF;
    @(negedge clk);
    exp_q.push_back(RESET_REC);
    check_cycle("midreset");
    rst = 1'b0; dv = 1'b0;
    push_frame(reset_vec, 16);
    push_frame(reset_vec, 16);
    for (int j = 1; j <= 32; j++) begin
      @(negedge clk);
      check_cycle("post_reset");
    end

    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL leftover: got %0d queued, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
